// File: rtl/noc_pkg.sv
// Shared NoC types and constants for router stages.
package noc_pkg;

    localparam int unsigned FLIT_WIDTH = 17;
    localparam int unsigned VALID_BIT  = 16;

    typedef logic [FLIT_WIDTH-1:0] flit_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
module rr_priority_picker #(
    parameter  int unsigned N_PORTS = 4,
    localparam int unsigned PTR_W   = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [N_PORTS-1:0] gnt_o,
    output logic               valid_o
);

    function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off);
        int unsigned sum;
        sum = base + off;
        return (sum >= N_PORTS) ? sum - N_PORTS : sum;
    endfunction

    // Scan offsets from the pointer; the first requesting port wins.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        for (int unsigned off = 0; off < N_PORTS; off++) begin
            for (int unsigned j = 0; j < N_PORTS; j++) begin
                if (!valid_o && req_i[j] && (j == wrap_add(32'(ptr_i), off))) begin
                    gnt_o[j] = 1'b1;
                    valid_o  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Router output-link arbiter: round-robin grant with burst lock, registered
// output slot with downstream ready/stall handshake.
module noc_output_arbiter #(
    parameter int unsigned N_PORTS    = 4,
    parameter int unsigned FLIT_WIDTH = 17,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_PORTS*FLIT_WIDTH-1:0] in_flit_i,
    output logic [N_PORTS-1:0]            in_ready_o,
    output logic [FLIT_WIDTH-1:0]         out_flit_o,
    input  logic                          out_ready_i,
    output logic [N_PORTS-1:0]            grant_o,
    output logic                          busy_o
);

    import noc_pkg::*;

    localparam int unsigned PTR_W = $clog2(N_PORTS);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam int unsigned VB    = FLIT_WIDTH - 1;

    arb_state_t              state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [N_PORTS-1:0]      grant_q, grant_d;
    logic [FLIT_WIDTH-1:0]   out_flit_q, out_flit_d;

    logic [FLIT_WIDTH-1:0]   flits [N_PORTS];
    logic [N_PORTS-1:0]      req;
    logic [FLIT_WIDTH-1:0]   owner_flit;
    logic [PTR_W-1:0]        owner_idx;
    logic                    owner_valid;
    logic [N_PORTS-1:0]      pick_gnt;
    logic                    pick_valid;
    logic                    slot_free;
    logic [N_PORTS-1:0]      in_ready;
    logic                    xfer;

    rr_priority_picker #(
        .N_PORTS (N_PORTS)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid)
    );

    // Unpack port flits, derive requests, and select the current owner's flit.
    always_comb begin
        owner_flit = '0;
        owner_idx  = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            flits[i] = in_flit_i[i*FLIT_WIDTH +: FLIT_WIDTH];
            req[i]   = flits[i][VB];
            if (grant_q[i]) begin
                owner_flit = owner_flit | flits[i];
                owner_idx  = PTR_W'(i);
            end
        end
        owner_valid = owner_flit[VB];
        slot_free   = ~out_flit_q[VB] | out_ready_i;
        in_ready    = (state_q == BUSY && slot_free) ? grant_q : '0;
        xfer        = |(in_ready & req);
    end

    // Next-state: arbitration in IDLE, transfers and release in BUSY.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        out_flit_d = out_ready_i ? '0 : out_flit_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    grant_d = pick_gnt;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // Release on owner going invalid, or on the transfer that fills the burst.
                if (!owner_valid || (xfer && cnt_q == CNT_W'(MAX_BURST - 1))) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    ptr_d   = (owner_idx == PTR_W'(N_PORTS - 1)) ? '0 : owner_idx + 1'b1;
                end
                if (owner_valid && xfer) begin
                    out_flit_d = owner_flit;
                    if (cnt_q != CNT_W'(MAX_BURST - 1)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            out_flit_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            out_flit_q <= out_flit_d;
        end
    end

    assign in_ready_o = in_ready;
    assign out_flit_o = out_flit_q;
    assign grant_o    = grant_q;
    assign busy_o     = (state_q == BUSY);

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Self-checking bench for noc_output_arbiter: vector table plus scoreboarded sequences.
module tb_noc_output_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned FW = 17;
    localparam int unsigned MB = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP*FW-1:0]  in_flit;
    logic [NP-1:0]     in_ready;
    logic [FW-1:0]     out_flit;
    logic              out_ready;
    logic [NP-1:0]     grant;
    logic              busy;

    logic [3*FW-1:0]   in3;
    logic [2:0]        rdy3;
    logic [FW-1:0]     out3;
    logic              out_ready3;
    logic [2:0]        g3;
    logic              busy3;

    noc_output_arbiter #(
        .N_PORTS    (NP),
        .FLIT_WIDTH (FW),
        .MAX_BURST  (MB)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_flit_i   (in_flit),
        .in_ready_o  (in_ready),
        .out_flit_o  (out_flit),
        .out_ready_i (out_ready),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    noc_output_arbiter #(
        .N_PORTS    (3),
        .FLIT_WIDTH (FW),
        .MAX_BURST  (MB)
    ) u_dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_flit_i   (in3),
        .in_ready_o  (rdy3),
        .out_flit_o  (out3),
        .out_ready_i (out_ready3),
        .grant_o     (g3),
        .busy_o      (busy3)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    typedef struct {
        logic [NP*FW-1:0] flits;
        logic             ordy;
        logic [NP-1:0]    exp_rdy;
        logic [FW-1:0]    exp_out;
        logic [NP-1:0]    exp_grant;
        logic             exp_busy;
    } vec_t;

    vec_t          vecs [11];
    int unsigned   seq [NP];
    int unsigned   lim [NP];
    logic [FW-1:0] sb [$];
    logic [NP-1:0] last_rdy;

    logic [NP-1:0] glog [$];
    int unsigned   gaps [$];
    int unsigned   zrun;
    bit            seen;
    logic [NP-1:0] prevg;
    logic [NP-1:0] exp_order [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    function automatic logic [FW-1:0] src_flit(input int unsigned p);
        if (seq[p] < lim[p]) return {1'b1, 4'(p), 12'(seq[p])};
        return 17'h0ABCD;
    endfunction

    function automatic bit srcs_done();
        for (int unsigned p = 0; p < NP; p++) if (seq[p] < lim[p]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit all_idle();
        return (sb.size() == 0) && (out_flit == '0) && !busy && srcs_done();
    endfunction

    task automatic drive_srcs();
        for (int unsigned p = 0; p < NP; p++) in_flit[p*FW +: FW] = src_flit(p);
    endtask

    // One clock of source-driven traffic; accepted output flits checked against the scoreboard.
    task automatic cycle();
        logic [FW-1:0] want;
        drive_srcs();
        #2;
        last_rdy = in_ready;
        if (out_flit[FW-1] && out_ready) begin
            if (sb.size() == 0) chk("sb_unexpected", 32'(out_flit), 32'h0);
            else begin
                want = sb.pop_front();
                chk("sb_flit", 32'(out_flit), 32'(want));
            end
        end else if (!out_flit[FW-1]) begin
            chk("idle_zero", 32'(out_flit), 32'h0);
        end
        for (int unsigned p = 0; p < NP; p++) begin
            if (last_rdy[p] && seq[p] < lim[p]) begin
                sb.push_back(src_flit(p));
                seq[p]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int unsigned budget);
        int unsigned k = 0;
        while (!all_idle() && k < budget) begin
            cycle();
            k++;
        end
        chk({name, "_drained"}, 32'(all_idle()), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{{17'h0,     17'h10001, 17'h0ABCD, 17'h0}, 1'b1, 4'b0000, 17'h0,     4'b0100, 1'b1};
        vecs[1]  = '{{17'h0,     17'h10001, 17'h0ABCD, 17'h0}, 1'b1, 4'b0100, 17'h10001, 4'b0100, 1'b1};
        vecs[2]  = '{{17'h0,     17'h10002, 17'h0ABCD, 17'h0}, 1'b1, 4'b0100, 17'h10002, 4'b0100, 1'b1};
        vecs[3]  = '{{17'h0,     17'h10003, 17'h0ABCD, 17'h0}, 1'b1, 4'b0100, 17'h10003, 4'b0100, 1'b1};
        vecs[4]  = '{{17'h0,     17'h0,     17'h0ABCD, 17'h0}, 1'b1, 4'b0100, 17'h0,     4'b0000, 1'b0};
        vecs[5]  = '{{17'h1AAAA, 17'h10005, 17'h0ABCD, 17'h0}, 1'b1, 4'b0000, 17'h0,     4'b1000, 1'b1};
        vecs[6]  = '{{17'h0,     17'h10005, 17'h0ABCD, 17'h0}, 1'b1, 4'b1000, 17'h0,     4'b0000, 1'b0};
        vecs[7]  = '{{17'h0,     17'h10005, 17'h0ABCD, 17'h0}, 1'b1, 4'b0000, 17'h0,     4'b0100, 1'b1};
        vecs[8]  = '{{17'h0,     17'h0,     17'h0ABCD, 17'h0}, 1'b1, 4'b0100, 17'h0,     4'b0000, 1'b0};
        vecs[9]  = '{{17'h1AAAA, 17'h0,     17'h0ABCD, 17'h0}, 1'b1, 4'b0000, 17'h0,     4'b1000, 1'b1};
        vecs[10] = '{{17'h0,     17'h0,     17'h0ABCD, 17'h0}, 1'b1, 4'b1000, 17'h0,     4'b0000, 1'b0};
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int unsigned p = 0; p < NP; p++) begin
            seq[p] = 0;
            lim[p] = 0;
        end

        // Reset with requests present: outputs zero, no ready while idle.
        rst_n      = 1'b0;
        out_ready  = 1'b1;
        out_ready3 = 1'b1;
        in3        = '0;
        in_flit    = {4{17'h10001}};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out",   32'(out_flit), 32'h0);
        chk("reset_grant", 32'(grant),    32'h0);
        chk("reset_busy",  32'(busy),     32'h0);
        chk("reset_rdy",   32'(in_ready), 32'h0);
        in_flit = '0;
        rst_n   = 1'b1;

        // Single requester, release on invalid, pointer advance, invalid non-owner.
        for (int i = 0; i < 11; i++) begin
            in_flit   = vecs[i].flits;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_rdy", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out", i),   32'(out_flit), 32'(vecs[i].exp_out));
            chk($sformatf("v%0d_grant", i), 32'(grant),    32'(vecs[i].exp_grant));
            chk($sformatf("v%0d_busy", i),  32'(busy),     32'(vecs[i].exp_busy));
        end

        // Round robin with all ports requesting.
        lim[0] = 8; lim[1] = 4; lim[2] = 4; lim[3] = 4;
        zrun = 0; seen = 1'b0; prevg = '0;
        for (int k = 0; k < 60 && !all_idle(); k++) begin
            cycle();
            if (grant != '0) begin
                if (grant != prevg) glog.push_back(grant);
                if (seen && zrun > 0) gaps.push_back(zrun);
                zrun = 0;
                seen = 1'b1;
            end else if (seen) begin
                zrun++;
            end
            prevg = grant;
        end
        chk("rr_done", 32'(all_idle()), 32'h1);
        chk("rr_grant_count", glog.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < glog.size()) chk($sformatf("rr_order%0d", i), 32'(glog[i]), 32'(exp_order[i]));
        chk("rr_gap_count", gaps.size(), 32'd4);
        for (int i = 0; i < gaps.size(); i++) chk($sformatf("rr_bubble%0d", i), gaps[i], 32'd1);

        // Backpressure on port 1.
        seq[1] = 16; lim[1] = 19;
        cycle();
        chk("bp_grant", 32'(grant), 32'h2);
        cycle();
        chk("bp_first", 32'(out_flit), 32'({1'b1, 4'd1, 12'd16}));
        out_ready = 1'b0;
        repeat (3) begin
            cycle();
            chk("bp_stall_rdy",  32'(last_rdy), 32'h0);
            chk("bp_stall_hold", 32'(out_flit), 32'({1'b1, 4'd1, 12'd16}));
        end
        out_ready = 1'b1;
        drain("bp", 20);

        // Pointer wrap after a grant to port 3.
        seq[3] = 32; lim[3] = 33;
        cycle();
        chk("wrap_g3", 32'(grant), 32'h8);
        drain("wrap_a", 10);
        seq[0] = 48; lim[0] = 49;
        seq[3] = 40; lim[3] = 41;
        cycle();
        chk("wrap_to_0", 32'(grant), 32'h1);
        lim[3] = seq[3];
        drain("wrap_b", 10);

        // Reset during port 0's second flit.
        seq[0] = 64; lim[0] = 72;
        cycle();
        chk("rst_pre_grant", 32'(grant), 32'h1);
        cycle();
        chk("rst_first", 32'(out_flit), 32'({1'b1, 4'd0, 12'd64}));
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        sb.delete();
        lim[0] = seq[0];
        chk("rst_mid_out",   32'(out_flit), 32'h0);
        chk("rst_mid_grant", 32'(grant),    32'h0);
        chk("rst_mid_busy",  32'(busy),     32'h0);
        seq[0] = 80; lim[0] = 81;
        seq[1] = 88; lim[1] = 89;
        cycle();
        chk("rst_ptr0_wins", 32'(grant), 32'h1);
        drain("rst", 20);
        chk("sb_empty", sb.size(), 32'd0);

        // Three-port instance: pointer wraps 2 -> 0.
        in3 = {17'h0, 17'h10111, 17'h0};
        @(posedge clk); #1;
        chk("n3_grant1", 32'(g3),    32'h2);
        chk("n3_busy",   32'(busy3), 32'h1);
        #1;
        chk("n3_rdy",    32'(rdy3),  32'h2);
        @(posedge clk); #1;
        chk("n3_out",    32'(out3),  32'h10111);
        in3 = '0;
        @(posedge clk); #1;
        chk("n3_rel1",   32'(g3),    32'h0);
        in3 = {17'h10222, 17'h0, 17'h0};
        @(posedge clk); #1;
        chk("n3_grant2", 32'(g3),    32'h4);
        @(posedge clk); #1;
        in3 = '0;
        @(posedge clk); #1;
        chk("n3_rel2",   32'(g3),    32'h0);
        in3 = {17'h10333, 17'h10111, 17'h10001};
        @(posedge clk); #1;
        chk("n3_wrap0",  32'(g3),    32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
